mii_tx_arbiter: RTL and testbench

Frame scheduler that shares one MAC-side MII transmit port (the txen/txer/txd inputs of the RMII/SMII PHY interface) between NREQ byte-stream requesters. It round-robin arbitrates whole frames, prepends preamble+SFD, and serialises bytes to nibbles (low nibble first). It aborts underrunning frames with txer and enforces the inter-frame gap. It runs in the MII TX clock domain, driven by the PHY interface's mac_mii_txc/mac_mii_txrst.

---
 rtl/mii_tx_arb_pkg.sv | 47 ++++
 rtl/mii_tx_arbiter_rr.sv | 37 +++
 rtl/mii_tx_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mii_tx_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mii_tx_arb_pkg.sv
// Shared types and constants for the MII transmit frame arbiter.
// Contents: FSM state enum, preamble/SFD nibbles, preamble length,
// CRC-32 constants and a byte-wise reflected CRC-32 update helper
// (used when MII_TX_ARB_FCS_EN is defined).
package mii_tx_arb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        DATA,
        FCS,
        ERR,
        IFG
    } arb_state_t;

    localparam logic [3:0]  PREAMBLE_NIBBLE = 4'h5;
    localparam logic [3:0]  SFD_NIBBLE      = 4'hD;
    localparam int unsigned PRE_LEN         = 16;

    localparam logic [31:0] CRC_POLY        = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT        = 32'hFFFF_FFFF;

    // Bit-reverse a 32-bit word (normal <-> reflected polynomial form).
    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    localparam logic [31:0] CRC_POLY_REFL = reflect32(CRC_POLY);

    // Reflected CRC-32 update over one byte, LSB first (same order as the
    // nibbles leave on the wire: low nibble, then high nibble).
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc_in ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/mii_tx_arbiter_rr.sv
// Round-robin arbiter: picks the first asserted request at or after ptr,
// wrapping around. Purely combinational.
// Ports:
//   req       in  NREQ   request vector
//   ptr       in  PTR_W  index with highest priority this round
//   grant     out NREQ   one-hot winner, 0 when no request
//   grant_idx out PTR_W  binary index of the winner, 0 when no request
module rr_arbiter #(
    parameter  int unsigned NREQ  = 2,
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [PTR_W-1:0] grant_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Scan NREQ positions starting at ptr; the first hit wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            idx = PTR_W'((int'(ptr) + i) % int'(NREQ));
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/mii_tx_arbiter.sv
// Shares one MII transmit port between NREQ byte-stream requesters.
// Whole frames are arbitrated round-robin, preamble+SFD is prepended,
// bytes are sent low nibble first, an underrun ends the frame with two
// txer cycles, and IFG_NIBBLES txen-low cycles separate frames.
// Optional feature: define MII_TX_ARB_FCS_EN to append a CRC-32 FCS.
// IFG_NIBBLES must be at least 2.
// Ports:
//   mii_txc      in   MII TX clock
//   mii_txrst    in   asynchronous active-high reset
//   s_valid      in   per-requester byte valid
//   s_ready      out  per-requester byte accept (combinational)
//   s_data       in   requester i byte at [8i+7:8i]
//   s_last       in   byte is final payload byte of its frame
//   grant        out  one-hot owner of current frame, 0 when idle
//   busy         out  FSM not in IDLE
//   frame_abort  out  one-cycle pulse on underrun abort
//   mii_txen/mii_txer/mii_txd  out  MII transmit interface
module mii_tx_arbiter
    import mii_tx_arb_pkg::*;
#(
    parameter int unsigned NREQ        = 2,
    parameter int unsigned IFG_NIBBLES = 24
) (
    input  logic              mii_txc,
    input  logic              mii_txrst,
    input  logic [NREQ-1:0]   s_valid,
    output logic [NREQ-1:0]   s_ready,
    input  logic [8*NREQ-1:0] s_data,
    input  logic [NREQ-1:0]   s_last,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic              frame_abort,
    output logic              mii_txen,
    output logic              mii_txer,
    output logic [3:0]        mii_txd
);

    localparam int unsigned PTR_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_MAX = (IFG_NIBBLES > PRE_LEN) ? IFG_NIBBLES : PRE_LEN;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             phase;     // current output cycle is a byte-accept slot
    logic             last_r;    // byte in flight is the last of the frame
    logic             tail;      // high nibble of the last byte is on the wire
    logic [3:0]       hi_nib;
    logic [PTR_W-1:0] own_idx;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] arb_idx;
    logic [NREQ-1:0]  arb_grant;
    logic [7:0]       cur_byte;
    logic             cur_valid;
    logic             cur_last;
`ifdef MII_TX_ARB_FCS_EN
    logic [31:0]      crc;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req       (s_valid),
        .ptr       (rr_ptr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // Ready only in accept slots (SFD and non-final high nibbles); during the
    // final high nibble a byte would belong to the next frame, so none is taken.
    assign s_ready = (state == DATA && phase) ? grant : '0;

    // Mux the owning requester's stream.
    always_comb begin
        cur_byte  = '0;
        cur_valid = 1'b0;
        cur_last  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (own_idx == PTR_W'(i)) begin
                cur_byte  = s_data[8*i +: 8];
                cur_valid = s_valid[i];
                cur_last  = s_last[i];
            end
        end
    end

    // Frame FSM with registered MII outputs.
    always_ff @(posedge mii_txc or posedge mii_txrst) begin
        if (mii_txrst) begin
            state       <= IDLE;
            cnt         <= '0;
            phase       <= 1'b0;
            last_r      <= 1'b0;
            tail        <= 1'b0;
            hi_nib      <= '0;
            own_idx     <= '0;
            rr_ptr      <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            frame_abort <= 1'b0;
            mii_txen    <= 1'b0;
            mii_txer    <= 1'b0;
            mii_txd     <= '0;
`ifdef MII_TX_ARB_FCS_EN
            crc         <= CRC_INIT;
`endif
        end else begin
            frame_abort <= 1'b0;
            case (state)
                IDLE: begin
                    if (|s_valid) begin
                        state    <= PRE;
                        busy     <= 1'b1;
                        grant    <= arb_grant;
                        own_idx  <= arb_idx;
                        rr_ptr   <= (arb_idx == PTR_W'(NREQ - 1)) ? '0 : arb_idx + PTR_W'(1);
                        mii_txen <= 1'b1;
                        mii_txd  <= PREAMBLE_NIBBLE;
                        cnt      <= CNT_W'(1);
                        phase    <= 1'b0;
                        last_r   <= 1'b0;
                        tail     <= 1'b0;
`ifdef MII_TX_ARB_FCS_EN
                        crc      <= CRC_INIT;
`endif
                    end
                end
                PRE: begin
                    if (cnt == CNT_W'(PRE_LEN - 1)) begin
                        state   <= DATA;
                        mii_txd <= SFD_NIBBLE;
                        phase   <= 1'b1;
                    end else begin
                        mii_txd <= PREAMBLE_NIBBLE;
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (tail) begin
`ifdef MII_TX_ARB_FCS_EN
                        state   <= FCS;
                        mii_txd <= ~crc[3:0];
                        crc     <= {4'h0, crc[31:4]};
                        cnt     <= CNT_W'(1);
`else
                        state    <= IFG;
                        mii_txen <= 1'b0;
                        mii_txd  <= '0;
                        grant    <= '0;
                        cnt      <= '0;
`endif
                    end else if (phase) begin
                        if (cur_valid) begin
                            mii_txd <= cur_byte[3:0];
                            hi_nib  <= cur_byte[7:4];
                            last_r  <= cur_last;
                            phase   <= 1'b0;
`ifdef MII_TX_ARB_FCS_EN
                            crc     <= crc32_byte(crc, cur_byte);
`endif
                        end else begin
                            state       <= ERR;
                            mii_txer    <= 1'b1;
                            mii_txd     <= '0;
                            frame_abort <= 1'b1;
                            phase       <= 1'b0;
                            cnt         <= '0;
                        end
                    end else begin
                        mii_txd <= hi_nib;
                        if (last_r) begin
                            tail <= 1'b1;
                        end else begin
                            phase <= 1'b1;
                        end
                    end
                end
`ifdef MII_TX_ARB_FCS_EN
                FCS: begin
                    if (cnt == CNT_W'(8)) begin
                        state    <= IFG;
                        mii_txen <= 1'b0;
                        mii_txd  <= '0;
                        grant    <= '0;
                        cnt      <= '0;
                    end else begin
                        mii_txd <= ~crc[3:0];
                        crc     <= {4'h0, crc[31:4]};
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
`endif
                ERR: begin
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        state    <= IFG;
                        mii_txen <= 1'b0;
                        mii_txer <= 1'b0;
                        mii_txd  <= '0;
                        grant    <= '0;
                        cnt      <= '0;
                    end
                end
                IFG: begin
                    // The single IDLE cycle completes the IFG_NIBBLES low gap.
                    if (cnt == CNT_W'(IFG_NIBBLES - 2)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Scoreboard bench for mii_tx_arbiter (NREQ=2, IFG_NIBBLES=24).
`timescale 1ns/1ps
module tb_mii_tx_arbiter;

    localparam int NREQ = 2;
    localparam int IFG  = 24;
    localparam logic [1:0] R0 = 2'd0;   // s_ready must be 0
    localparam logic [1:0] RG = 2'd1;   // s_ready must equal grant
    localparam logic [1:0] RX = 2'd2;   // s_ready not checked

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   s_valid;
    logic [NREQ-1:0]   s_ready;
    logic [8*NREQ-1:0] s_data;
    logic [NREQ-1:0]   s_last;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic              frame_abort;
    logic              mii_txen;
    logic              mii_txer;
    logic [3:0]        mii_txd;

    typedef struct packed {
        logic            txer;
        logic [3:0]      txd;
        logic [NREQ-1:0] grant;
        logic [1:0]      rdy;
    } exp_t;

    exp_t       exp_q[$];
    int         len_q[$];
    int         rise_q[$];
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    int checks    = 0;
    int errors    = 0;
    int exp_abort = 0;
    int abort_cnt = 0;
    int cyc       = 0;

    mii_tx_arbiter #(.NREQ(NREQ), .IFG_NIBBLES(IFG)) dut (
        .mii_txc     (clk),
        .mii_txrst   (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .grant       (grant),
        .busy        (busy),
        .frame_abort (frame_abort),
        .mii_txen    (mii_txen),
        .mii_txer    (mii_txer),
        .mii_txd     (mii_txd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

`ifdef MII_TX_ARB_FCS_EN
    // Reflected CRC-32 advanced one wire nibble at a time.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
        logic [31:0] x;
        x = c ^ {28'h0, n};
        for (int k = 0; k < 4; k++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB8_8320) : (x >> 1);
        end
        return x;
    endfunction
`endif

    task automatic push_nib(input logic txer, input logic [3:0] txd,
                            input logic [NREQ-1:0] g, input logic [1:0] rdy);
        exp_t e;
        e.txer  = txer;
        e.txd   = txd;
        e.grant = g;
        e.rdy   = rdy;
        exp_q.push_back(e);
    endtask

    // Queue a frame at requester r and its expected wire image.
    task automatic push_frame(input int r, input logic [7:0] d[], input bit complete);
        logic [NREQ-1:0] g;
        logic [8:0]      w;
        bit              lst;
        int              len;
`ifdef MII_TX_ARB_FCS_EN
        logic [31:0]     crc;
        crc = 32'hFFFF_FFFF;
`endif
        g = NREQ'(1) << r;
        for (int i = 0; i < 15; i++) push_nib(1'b0, 4'h5, g, R0);
        push_nib(1'b0, 4'hD, g, RG);
        foreach (d[i]) begin
            lst = complete && (i == d.size() - 1);
            push_nib(1'b0, d[i][3:0], g, R0);
            push_nib(1'b0, d[i][7:4], g, lst ? RX : RG);
            w = {lst, d[i]};
            if (r == 0) q0.push_back(w); else q1.push_back(w);
`ifdef MII_TX_ARB_FCS_EN
            crc = crc_nib(crc_nib(crc, d[i][3:0]), d[i][7:4]);
`endif
        end
        len = 16 + 2 * d.size();
        if (complete) begin
`ifdef MII_TX_ARB_FCS_EN
            crc = ~crc;
            for (int k = 0; k < 8; k++) push_nib(1'b0, crc[4*k +: 4], g, R0);
            len += 8;
`endif
        end else begin
            push_nib(1'b1, 4'h0, g, R0);
            push_nib(1'b1, 4'h0, g, R0);
            len += 2;
            exp_abort++;
        end
        len_q.push_back(len);
    endtask

    // Requester model: drives the head byte, pops it after a handshake.
    initial begin
        logic [NREQ-1:0] acc;
        s_valid = '0;
        s_data  = '0;
        s_last  = '0;
        forever begin
            @(negedge clk);
            acc = s_valid & s_ready;
            @(posedge clk);
            #1;
            if (acc[0] && q0.size() > 0) void'(q0.pop_front());
            if (acc[1] && q1.size() > 0) void'(q1.pop_front());
            s_valid = {q1.size() > 0, q0.size() > 0};
            s_data  = {(q1.size() > 0) ? q1[0][7:0] : 8'h0, (q0.size() > 0) ? q0[0][7:0] : 8'h0};
            s_last  = {(q1.size() > 0) ? q1[0][8] : 1'b0, (q0.size() > 0) ? q0[0][8] : 1'b0};
        end
    end

    // Monitor: pops the scoreboard on every txen cycle, checks lengths/gaps.
    initial begin
        bit   prev_txen = 1'b0;
        bit   seen      = 1'b0;
        int   hi_cnt    = 0;
        int   lo_cnt    = 0;
        int   elen;
        exp_t e;
        logic [NREQ-1:0] er;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_txen = 1'b0;
                seen      = 1'b0;
                hi_cnt    = 0;
                lo_cnt    = 0;
            end else begin
                if (frame_abort) abort_cnt++;
                if (mii_txen) begin
                    if (!prev_txen) begin
                        rise_q.push_back(cyc);
                        if (seen) chk("ifg_gap", lo_cnt >= IFG, 64'(lo_cnt), 64'(IFG));
                        hi_cnt = 0;
                    end
                    hi_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_nibble", 1'b0, {mii_txer, mii_txd}, 64'h0);
                    end else begin
                        e  = exp_q.pop_front();
                        er = (e.rdy == RG) ? e.grant : '0;
                        chk("nibble {txer,txd,grant,busy,ready}",
                            mii_txer == e.txer && mii_txd == e.txd && grant == e.grant && busy
                            && (e.rdy == RX || s_ready == er),
                            {mii_txer, mii_txd, grant, busy, s_ready},
                            {e.txer, e.txd, e.grant, 1'b1, er});
                    end
                end else begin
                    if (prev_txen) begin
                        seen   = 1'b1;
                        lo_cnt = 0;
                        if (len_q.size() == 0) begin
                            chk("txen_len_unexpected", 1'b0, 64'(hi_cnt), 64'h0);
                        end else begin
                            elen = len_q.pop_front();
                            chk("txen_len", hi_cnt == elen, 64'(hi_cnt), 64'(elen));
                        end
                    end
                    lo_cnt++;
                    chk("idle {ready,txer,txd,grant}",
                        s_ready == '0 && !mii_txer && mii_txd == 4'h0 && grant == '0,
                        {s_ready, mii_txer, mii_txd, grant}, 64'h0);
                end
                prev_txen = mii_txen;
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk(name, {mii_txen, mii_txer, mii_txd, grant, busy, frame_abort, s_ready} == '0,
            {mii_txen, mii_txer, mii_txd, grant, busy, frame_abort, s_ready}, 64'h0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        len_q.delete();
        q0.delete();
        q1.delete();
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, n < 5000, 64'(exp_q.size()), 64'h0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_grant(input string name, input logic [NREQ-1:0] g);
        int n = 0;
        while (grant != g && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(name, grant == g, 64'(grant), 64'(g));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] fr[];
        int         per;

        // Single frame from requester 0.
        do_reset();
        fr = '{8'h10, 8'h32, 8'h54};
        push_frame(0, fr, 1'b1);
        wait_idle("t1_single");

        // Both requesters valid from reset: rotation over four frames.
        do_reset();
        fr = '{8'hA1, 8'hB2};
        push_frame(0, fr, 1'b1);
        fr = '{8'hC3, 8'hD4, 8'hE5};
        push_frame(1, fr, 1'b1);
        fr = '{8'hF6};
        push_frame(0, fr, 1'b1);
        fr = '{8'h07, 8'h18};
        push_frame(1, fr, 1'b1);
        wait_idle("t2_rotation");

        // Requester 1 underruns after two bytes, then requester 0 is served.
        fr = '{8'h21, 8'h43};
        push_frame(1, fr, 1'b0);
        wait_grant("t3_grant_req1", 2'b10);
        fr = '{8'hA5, 8'h5A};
        push_frame(0, fr, 1'b1);
        wait_idle("t3_underrun");
        chk("t3_abort_pulses", abort_cnt == exp_abort, 64'(abort_cnt), 64'(exp_abort));

        // Sixty zero bytes (FCS appended when the feature is built in).
        fr = new[60];
        foreach (fr[i]) fr[i] = 8'h00;
        push_frame(0, fr, 1'b1);
        wait_idle("t4_zeros");

        // Reset in the middle of the payload, then a full restart.
        fr = '{8'h11, 8'h22, 8'h33, 8'h44};
        push_frame(0, fr, 1'b1);
        wait_grant("t5_grant_req0", 2'b01);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        check_all_zero("t5_midframe_reset");
        exp_q.delete();
        len_q.delete();
        q0.delete();
        q1.delete();
        push_frame(0, fr, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        wait_idle("t5_restart");

        // Back-to-back one-byte frames: fixed txen period.
        rise_q.delete();
        fr = '{8'h9C};
        for (int k = 0; k < 3; k++) push_frame(0, fr, 1'b1);
        wait_idle("t6_continuous");
`ifdef MII_TX_ARB_FCS_EN
        per = 18 + 8 + IFG;
`else
        per = 18 + IFG;
`endif
        chk("t6_rise_count", rise_q.size() == 3, 64'(rise_q.size()), 64'd3);
        if (rise_q.size() == 3) begin
            chk("t6_period_1", rise_q[1] - rise_q[0] == per, 64'(rise_q[1] - rise_q[0]), 64'(per));
            chk("t6_period_2", rise_q[2] - rise_q[1] == per, 64'(rise_q[2] - rise_q[1]), 64'(per));
        end

        chk("final_abort_pulses", abort_cnt == exp_abort, 64'(abort_cnt), 64'(exp_abort));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
